// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//   Memory-side responder for the SLC-3 CPU bus. Serves active-low OE/WE
//   requests from an on-chip word RAM. Each transaction waits a programmable
//   number of cycles, then acknowledges with a one-cycle Ready pulse.
//   Address 16'hFFFF is memory-mapped I/O: a read returns the board switches
//   and a write loads the hex display register.
//
// Ports
//   Clk            in   1   system clock, rising edge
//   Reset          in   1   asynchronous, active-low reset
//   ADDR           in   16  word address from MAR
//   Data_from_CPU  in   16  write data from MDR
//   OE             in   1   active-low read request
//   WE             in   1   active-low write request (wins over OE)
//   Switches       in   10  board switches, visible at 16'hFFFF
//   Data_to_CPU    out  16  last completed read value
//   Ready          out  1   one-cycle completion pulse
//   Hex_out        out  16  hex display register (HEX3..HEX0 nibbles)
//   Busy           out  1   high while a transaction is in WAIT or DONE
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic        OE,
    input  logic        WE,
    input  logic [9:0]  Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic [15:0] Hex_out,
    output logic        Busy
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;

    // Request attributes frozen at capture; later bus changes are ignored.
    logic [15:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_write;

    logic        req;
    logic        capture;
    logic        load_read;
    logic        commit;
    logic        is_io;
    logic        in_ram;
    logic [15:0] read_value;

    logic [15:0] ram [DEPTH];

    assign req = ~OE | ~WE;

    // I/O decode takes priority so the map stays correct even if the RAM
    // were sized to cover the whole 16-bit space.
    assign is_io  = (cap_addr == IO_ADDR);
    assign in_ram = !is_io && ({16'b0, cap_addr} < 32'(DEPTH));

    always_comb begin
        read_value = 16'h0000;
        if (is_io) begin
            read_value = {6'b0, Switches};
        end else if (in_ram) begin
            read_value = ram[cap_addr[ADDR_W-1:0]];
        end
    end

    // NOTE: every output of this block is given a default first so that no
    // path through the case statement leaves a signal unassigned (no latch).
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        load_read     = 1'b0;
        commit        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    capture       = 1'b1;
                    wait_cnt_next = 4'(WAIT_STATES);
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                // An abandoned request leaves without side effects.
                if (!req) begin
                    state_next = S_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    load_read  = !cap_write;
                    state_next = S_DONE;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_DONE: begin
                commit     = cap_write;
                state_next = S_HOLD;
            end
            S_HOLD: begin
                // Wait for the request to drop so one assertion is one transaction.
                if (!req) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cap_addr    <= 16'h0000;
            cap_data    <= 16'h0000;
            cap_write   <= 1'b0;
            Data_to_CPU <= 16'h0000;
            Hex_out     <= 16'h0000;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (capture) begin
                cap_addr  <= ADDR;
                cap_data  <= Data_from_CPU;
                cap_write <= ~WE;
            end
            if (load_read) begin
                Data_to_CPU <= read_value;
            end
            if (commit && is_io) begin
                Hex_out <= cap_data;
            end
        end
    end

    // NOTE: the RAM array has no reset; its contents survive Reset and it
    // maps onto plain memory without a clear path.
    always_ff @(posedge Clk) begin
        if (commit && in_ram) begin
            ram[cap_addr[ADDR_W-1:0]] <= cap_data;
        end
    end

    assign Ready = (state == S_DONE);
    assign Busy  = (state == S_WAIT) || (state == S_DONE);

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//   Two responders share the bus lines but have private OE/WE strobes:
//   instance A with WAIT_STATES=2, instance B with WAIT_STATES=0.
//   A transaction-level model decides, when a request is issued, whether it
//   completes (request held long enough), on which cycle Ready appears and
//   what Data_to_CPU / Hex_out must show; results are queued per instance
//   and a negedge monitor pops and compares whenever Ready is seen.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    localparam int WS_A  = 2;
    localparam int WS_B  = 0;
    localparam int DEPTH = 256;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [9:0]  Switches;
    logic        oe_a, we_a, oe_b, we_b;
    logic [15:0] dout_a, hex_a, dout_b, hex_b;
    logic        rdy_a, busy_a, rdy_b, busy_b;

    sram_responder #(.ADDR_W(8), .WAIT_STATES(WS_A)) dut_a (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .OE(oe_a), .WE(we_a), .Switches(Switches), .Data_to_CPU(dout_a),
        .Ready(rdy_a), .Hex_out(hex_a), .Busy(busy_a)
    );

    sram_responder #(.ADDR_W(8), .WAIT_STATES(WS_B)) dut_b (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .OE(oe_b), .WE(we_b), .Switches(Switches), .Data_to_CPU(dout_b),
        .Ready(rdy_b), .Hex_out(hex_b), .Busy(busy_b)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned exp_cyc;
        logic [15:0] data;
        logic [15:0] hex;
    } txn_t;

    txn_t        q_a[$];
    txn_t        q_b[$];
    logic [15:0] mem_m [2][DEPTH];
    logic [15:0] hex_m [2];
    logic [15:0] last_m[2];
    bit          hex_pend[2];
    logic [15:0] hex_pend_val[2];
    logic [15:0] pool[5] = '{16'h0000, 16'h0010, 16'h0020, 16'h007F, 16'h00FF};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor(input int d, input logic rdy, input logic [15:0] dout,
                           input logic [15:0] hex, input logic busy);
        txn_t it;
        int   n;
        if (hex_pend[d]) begin
            check("hex_after_ready", hex, hex_pend_val[d]);
            check("ready_single_cycle", rdy, 1'b0);
            hex_pend[d] = 1'b0;
        end
        if (rdy) begin
            n = (d == 0) ? q_a.size() : q_b.size();
            check("ready_expected", 32'(n > 0), 1);
            if (n > 0) begin
                if (d == 0) it = q_a.pop_front();
                else        it = q_b.pop_front();
                check("ready_latency", cyc, it.exp_cyc);
                check("data_to_cpu", dout, it.data);
                check("busy_in_done", busy, 1'b1);
                hex_pend[d]     = 1'b1;
                hex_pend_val[d] = it.hex;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            monitor(0, rdy_a, dout_a, hex_a, busy_a);
            monitor(1, rdy_b, dout_b, hex_b, busy_b);
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic set_strobes(input int d, input logic oe, input logic we);
        if (d == 0) begin oe_a = oe; we_a = we; end
        else        begin oe_b = oe; we_b = we; end
    endtask

    // kind: 0 = read (OE low), 1 = write (WE low), 2 = both low (a write).
    // h: number of cycles the request stays asserted.
    task automatic txn(input int d, input int kind, input logic [15:0] a,
                       input logic [15:0] wd, input int h);
        int   ws;
        txn_t it;
        ws = (d == 0) ? WS_A : WS_B;
        @(negedge Clk);
        ADDR          = a;
        Data_from_CPU = wd;
        set_strobes(d, (kind == 1), (kind == 0));
        // Ready needs the request seen at capture plus ws+1 wait cycles.
        if (h >= ws + 2) begin
            if (kind != 0) begin
                if (a < DEPTH)          mem_m[d][a] = wd;
                else if (a == 16'hFFFF) hex_m[d]    = wd;
            end else begin
                if (a < DEPTH)          last_m[d] = mem_m[d][a];
                else if (a == 16'hFFFF) last_m[d] = {6'b0, Switches};
                else                    last_m[d] = 16'h0000;
            end
            it.exp_cyc = cyc + ws + 2;
            it.data    = last_m[d];
            it.hex     = hex_m[d];
            if (d == 0) q_a.push_back(it);
            else        q_b.push_back(it);
        end
        repeat (h) begin
            @(negedge Clk);
            ADDR          = 16'($urandom);
            Data_from_CPU = 16'($urandom);
        end
        set_strobes(d, 1'b1, 1'b1);
        // Released while still in DONE: allow HOLD to see the release first.
        if (h == ws + 2) @(negedge Clk);
    endtask

    task automatic reset_mid_write;
        @(negedge Clk);
        ADDR          = 16'hFFFF;
        Data_from_CPU = 16'hFFFF;
        we_a          = 1'b0;
        @(negedge Clk);
        check("busy_in_wait", busy_a, 1'b1);
        Reset = 1'b0;
        #1;
        check("rst_mid_ready", rdy_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_hex", hex_a, 16'h0000);
        we_a = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst_mid_hex_later", hex_a, 16'h0000);
        check("rst_mid_dout", dout_a, 16'h0000);
        hex_m    = '{16'h0000, 16'h0000};
        last_m   = '{16'h0000, 16'h0000};
        hex_pend = '{1'b0, 1'b0};
        Reset    = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        int sel;
        int ws;
        logic [15:0] a;

        Reset = 1'b0;
        ADDR = '0; Data_from_CPU = '0; Switches = '0;
        oe_a = 1'b1; we_a = 1'b1; oe_b = 1'b1; we_b = 1'b1;
        hex_m  = '{16'h0000, 16'h0000};
        last_m = '{16'h0000, 16'h0000};
        #12;
        check("reset_ready_a", rdy_a, 1'b0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_hex_a", hex_a, 16'h0000);
        check("reset_dout_a", dout_a, 16'h0000);
        check("reset_ready_b", rdy_b, 1'b0);
        check("reset_hex_b", hex_b, 16'h0000);
        check("reset_dout_b", dout_b, 16'h0000);
        @(negedge Clk);
        Reset = 1'b1;

        // Preload the RAM pool on both instances.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 5; i++)
                txn(d, 1, pool[i], 16'($urandom), 6);

        // Write then read back, BEEF.
        txn(0, 1, 16'h0010, 16'hBEEF, 4);
        txn(0, 0, 16'h0010, 16'h0000, 4);
        // Switch read and hex write at 0xFFFF.
        Switches = 10'h2A5;
        txn(0, 0, 16'hFFFF, 16'h0000, 4);
        txn(0, 1, 16'hFFFF, 16'h1234, 4);
        // Long OE hold gives one pulse; a one-cycle release gives another.
        txn(0, 0, 16'h0010, 16'h0000, 10);
        txn(0, 0, 16'h0010, 16'h0000, 4);
        // Write aborted in WAIT leaves the old AAAA.
        txn(0, 1, 16'h0020, 16'hAAAA, 4);
        txn(0, 1, 16'h0020, 16'h5555, 2);
        txn(0, 0, 16'h0020, 16'h0000, 4);
        // Unmapped address: reads zero, writes dropped.
        txn(0, 0, 16'h0100, 16'h0000, 4);
        txn(0, 1, 16'h0100, 16'h7777, 4);
        txn(0, 2, 16'h0000, 16'h4321, 4);
        txn(0, 0, 16'h0000, 16'h0000, 4);
        // Reset during WAIT of a hex write, then zero-wait instance at k+1.
        repeat (3) @(negedge Clk);
        reset_mid_write();
        txn(1, 1, 16'hFFFF, 16'hFFFF, 2);
        txn(1, 0, 16'h0020, 16'h0000, 2);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            ws = (d == 0) ? WS_A : WS_B;
            for (int n = 0; n < 40; n++) begin
                kind = $urandom_range(0, 2);
                sel  = $urandom_range(0, 5);
                if (sel <= 2)      a = pool[$urandom_range(0, 4)];
                else if (sel == 3) a = 16'hFFFF;
                else               a = 16'h0100 + 16'($urandom_range(0, 16'hFEFE));
                Switches = 10'($urandom);
                txn(d, kind, a, 16'($urandom), $urandom_range(1, ws + 5));
            end
        end

        repeat (6) @(negedge Clk);
        check("sb_drain_a", q_a.size(), 0);
        check("sb_drain_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
